// File: rtl/inst_prefetch_queue.sv
// Prefetch queue: streams sequential instruction words from memory into a DEPTH-entry FWFT buffer for fetch.
// Latency: zero-wait memory gives an entry the cycle after ack; a redirect gives a new-target request next cycle.
// Backpressure: fetch_ready low stops pops; the memory request is withheld once the queue would be full.
module inst_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        fetch_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] pc_plus4,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [31:0]       fetch_addr;
    logic [31:0]       fetch_addr_next;
    logic [31:0]       drop_addr;
    logic [31:0]       drop_addr_next;
    logic [31:0]       redirect_tgt;
    logic              push;
    logic              pop;
    logic              room_next;

    logic [31:0]       pc_mem   [DEPTH];
    logic [31:0]       inst_mem [DEPTH];

    // Byte offset of a redirect target is meaningless for word fetches.
    assign redirect_tgt = {redirect_pc[31:2], 2'b00};
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = &{1'b0, redirect_pc[1:0]};

    assign inst_valid = (count != '0);
    assign pop        = inst_valid & fetch_ready;
    assign push       = (state == REQ) & mem_ack & ~redirect;

    // Occupancy after this edge; a redirect empties the queue regardless of push/pop.
    always_comb begin
        count_next = count;
        if (redirect) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + CNT_W'(1);
                2'b01:   count_next = count - CNT_W'(1);
                default: count_next = count;
            endcase
        end
    end

    assign room_next = (count_next < CNT_W'(DEPTH));

    always_comb begin
        state_next      = state;
        fetch_addr_next = fetch_addr;
        drop_addr_next  = drop_addr;
        mem_req         = 1'b0;
        mem_addr        = fetch_addr;
        case (state)
            IDLE: begin
                if (redirect) begin
                    fetch_addr_next = redirect_tgt;
                    state_next      = REQ;
                end else if (room_next) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (redirect) begin
                    fetch_addr_next = redirect_tgt;
                    // Outstanding request must still be retired, so remember where it went.
                    if (!mem_ack) begin
                        drop_addr_next = fetch_addr;
                        state_next     = DROP;
                    end
                end else if (mem_ack) begin
                    fetch_addr_next = fetch_addr + 32'd4;
                    if (!room_next) begin
                        state_next = IDLE;
                    end
                end
            end
            DROP: begin
                mem_req  = 1'b1;
                mem_addr = drop_addr;
                if (redirect) begin
                    fetch_addr_next = redirect_tgt;
                end
                if (mem_ack) begin
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            fetch_addr <= RESET_PC;
            drop_addr  <= '0;
        end else begin
            state      <= state_next;
            fetch_addr <= fetch_addr_next;
            drop_addr  <= drop_addr_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= fetch_addr;
            inst_mem[wr_ptr] <= mem_rdata;
        end
    end

    assign inst     = inst_valid ? inst_mem[rd_ptr] : 32'h0;
    assign inst_pc  = inst_valid ? pc_mem[rd_ptr] : 32'h0;
    assign pc_plus4 = inst_valid ? (pc_mem[rd_ptr] + 32'd4) : 32'h0;

    // Single outstanding request keeps a push from ever landing on a full queue.
    assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !pop && (count == CNT_W'(DEPTH))));

endmodule
